// File: rtl/alu_uart_pkg.sv
// ============================================================
// alu_uart_pkg : UART framing defaults and TX FSM encoding
// Rev 1.0
// ============================================================
`default_nettype none

package alu_uart_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 10417;  // 100 MHz / 9600 baud
  localparam int DEFAULT_SIZE_DATA    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;
endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================
// uart_bit_timer : bit-period counter, flags last cycle of a bit
// Rev 1.0
// ============================================================
`default_nettype none

module uart_bit_timer
  import alu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (i_clear || o_bit_end) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

  assign o_bit_end = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_result_tx.sv
// ============================================================
// uart_result_tx : 8N1 LSB-first serializer for ALU results
// Rev 1.0
// ============================================================
`default_nettype none

module uart_result_tx
  import alu_uart_pkg::*;
#(
  parameter int SIZE_DATA    = DEFAULT_SIZE_DATA,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_tx_start,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int IW = $clog2(SIZE_DATA + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(SIZE_DATA - 1);

  tx_state_t            state, state_next;
  logic [SIZE_DATA-1:0] shift, shift_next;
  logic [IW-1:0]        bit_idx, bit_idx_next;
  logic                 tx_next;
  logic                 done_next;
  logic                 bit_end;
  logic                 timer_clear;

  // Timer is held at zero while idle so bit edges align to the accept edge.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_clear   (timer_clear),
    .o_bit_end (bit_end)
  );

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      shift   <= '0;
      bit_idx <= '0;
      o_tx    <= 1'b1;
      o_done  <= 1'b0;
    end else begin
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      o_tx    <= tx_next;
      o_done  <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    timer_clear  = 1'b0;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (i_tx_start) begin
          state_next   = START;
          shift_next   = i_data;
          bit_idx_next = '0;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_next   = shift >> 1;
          bit_idx_next = bit_idx + IW'(1);
          if (bit_idx == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is computed from the next state so the output register
    // presents each bit in the same cycle the state enters it.
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule

`default_nettype wire

// File: doc/uart_result_tx.md
# uart_result_tx

- Serializes one ALU result word onto a UART TX line: 8N1 framing, LSB first.
- Closes the ALU loop: operands and opcode come in on the input side, and results go back out to the host over the serial line instead of only to LEDs.
- The board top zero-extends the ALU result to `SIZE_DATA` and drives `i_tx_start` when a result is ready.

## Interface
Parameters:
- `SIZE_DATA`, default 8: data bits per frame.
- `CLKS_PER_BIT`, default 10417: clock cycles per serial bit (100 MHz / 9600 baud). Must be ≥ 2.

Ports:
- `clock`  in  1  system clock.
- `i_reset`  in  1  reset, asynchronous, active-low.
- `i_tx_start`  in  1  transmit request; level-sampled on rising edges.
- `i_data`  in  `SIZE_DATA`  word to send; captured on acceptance.
- `o_tx`  out  1  serial line; idles high.
- `o_busy`  out  1  high while a frame is in progress.
- `o_done`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, STOP. Binary encoded; reset state is IDLE.
- IDLE:
  - `o_tx`=1, `o_busy`=0.
  - If `i_tx_start`=1 on an edge: latch `i_data` into the shift register, clear the bit timer and bit index, go to START.
- START:
  - `o_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `o_tx` = shift register bit 0.
  - After every `CLKS_PER_BIT` cycles, shift right by one and increment the bit index.
  - After `SIZE_DATA` bits, go to STOP.
- STOP:
  - `o_tx`=1 for `CLKS_PER_BIT` cycles, then return to IDLE and assert `o_done` for one cycle.
- `i_tx_start` is ignored outside IDLE. No queuing; a dropped request is the caller's responsibility.
- `i_data` changes after acceptance have no effect on the frame in flight.
- Bit timer:
  - Counts 0..`CLKS_PER_BIT`-1; width `$clog2(CLKS_PER_BIT)`.
  - Cleared at acceptance, so bit edges align to the accept edge and not to a free-running tick.
- Bit index width: `$clog2(SIZE_DATA+1)`.
- `o_tx` is driven from a register (glitch-free).
- Reset values: `o_tx`=1, `o_busy`=0, `o_done`=0. Shift register, timer and index are all 0.

## Timing
- Acceptance edge = cycle 0. `o_tx` falls in cycle 1.
- Frame length: `(SIZE_DATA+2)*CLKS_PER_BIT` cycles, i.e. cycles 1..`10*CLKS_PER_BIT` at the defaults.
- `o_busy` is high for exactly that window.
- `o_done` is high in cycle `(SIZE_DATA+2)*CLKS_PER_BIT+1`, the first IDLE cycle. `o_busy`=0 in that same cycle.
- Back-to-back: a start asserted in the `o_done` cycle is accepted, leaving exactly one idle-high cycle between stop bit and next start bit. A continuously held `i_tx_start` therefore sends frames with a 1-cycle gap.
- Reset mid-frame:
  - `o_tx` goes to 1 and `o_busy`/`o_done` go to 0 immediately (asynchronous); the frame is abandoned.
  - After `i_reset` deasserts, the block stays IDLE until a new start request.
- Reset and start together: reset wins; no frame is sent.

## Structure
- Shared package `alu_uart_pkg` holds:
  - the FSM state encoding constants (IDLE=0, START=1, DATA=2, STOP=3);
  - the default `CLKS_PER_BIT` and `SIZE_DATA` values, so a future `uart_cmd_rx` uses identical framing.
- Sub-module `uart_bit_timer`:
  - parameter `CLKS_PER_BIT`; inputs `clock`, `i_reset`, `i_clear`; output `o_bit_end`.
  - `o_bit_end` is high in the last cycle of each bit period.
- FSM, shift register and bit index live in `uart_result_tx`.
- Estimated size: ~150–200 lines of RTL.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `SIZE_DATA`=8.
- Reset: hold `i_reset`=0 for 3 cycles → `o_tx`=1, `o_busy`=0, `o_done`=0 throughout. No activity after release with `i_tx_start`=0.
- Single frame: pulse start with `i_data`=0xA5 at cycle 0 → `o_tx` shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles over cycles 1–40. `o_busy`=1 for cycles 1–40; `o_done`=1 only at cycle 41.
- Busy lockout: during the 0xA5 frame, assert start with `i_data`=0xFF at cycle 10 → waveform identical to the single-frame case; exactly one `o_done`.
- Data stability: change `i_data` from 0x3C to 0xC3 at cycle 2 → transmitted bits are 0x3C (0,0,1,1,1,1,0,0 LSB first).
- Back-to-back: hold start high with 0x00 then 0x81 → second start bit begins at cycle 42; `o_done` pulses at cycles 41 and 82.
- Reset mid-frame: assert `i_reset`=0 at cycle 15 (inside a DATA bit driving 0) → `o_tx`=1 and `o_busy`=0 within the same cycle. After release, a new 0x55 frame transmits correctly.
